// File: rtl/stage_memory_pkg.sv
// Shared types for the memory stage: memory op/size encodings, control word,
// pipeline signal, and small helpers for access sizing, alignment and
// deciding whether an instruction needs a bus transaction.
package stage_memory_pkg;

  typedef enum logic [2:0] {
    MEM_NONE  = 3'd0,
    MEM_LOAD  = 3'd1,
    MEM_STORE = 3'd2,
    MEM_LL    = 3'd3,
    MEM_SC    = 3'd4
  } mem_op_t;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } mem_size_t;

  typedef struct packed {
    logic      write_reg;
    logic      write_hilo;
    logic      write_cond;
    mem_op_t   mem_op;
    mem_size_t mem_size;
    logic      mem_signed;
  } control_t;

  typedef struct packed {
    control_t    control;
    logic [4:0]  dest_reg;
    logic [31:0] dest_reg_data;
    logic [31:0] mem_addr;
    logic [31:0] rt;
  } pipeline_signal_t;

  // LL and SC are always word accesses regardless of the size field.
  function automatic mem_size_t eff_size(mem_op_t op, mem_size_t size);
    if (op == MEM_LL || op == MEM_SC) return SIZE_WORD;
    return size;
  endfunction

  // Unused size encoding is treated as a word access.
  function automatic logic is_misaligned(mem_size_t size, logic [1:0] a);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return a[0];
      default:   return (a != 2'b00);
    endcase
  endfunction

  // SC only goes to the bus while the reservation is still held.
  function automatic logic needs_request(pipeline_signal_t s, logic ll);
    mem_op_t op;
    logic    go;
    op = s.control.mem_op;
    go = (op == MEM_LOAD) || (op == MEM_STORE) || (op == MEM_LL) ||
         ((op == MEM_SC) && ll);
    return go && !is_misaligned(eff_size(op, s.control.mem_size), s.mem_addr[1:0]);
  endfunction

endpackage

// File: rtl/memory_lane_align.sv
// Byte-lane steering for the data bus: store byte enables and replicated data,
// load byte/half extraction with sign or zero extension, alignment check.
// Purely combinational, no backpressure.
module memory_lane_align
  import stage_memory_pkg::*;
(
  input  mem_size_t   size_i,
  input  logic        signed_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rt_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o,
  output logic        misaligned_o
);

  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection and extension for each access size.
  always_comb begin
    shifted      = rdata_i >> {addr_lo_i, 3'b000};
    byte_sel     = shifted[7:0];
    half_sel     = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    misaligned_o = is_misaligned(size_i, addr_lo_i);
    be_o         = 4'b1111;
    wdata_o      = rt_i;
    load_data_o  = rdata_i;
    case (size_i)
      SIZE_BYTE: begin
        be_o        = 4'b0001 << addr_lo_i;
        wdata_o     = {4{rt_i[7:0]}};
        load_data_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
      end
      SIZE_HALF: begin
        be_o        = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o     = {2{rt_i[15:0]}};
        load_data_o = {{16{signed_i & half_sel[15]}}, half_sel};
      end
      default: begin
        be_o        = 4'b1111;
        wdata_o     = rt_i;
        load_data_o = rdata_i;
      end
    endcase
  end

endmodule

// File: rtl/stage_memory.sv
// Memory pipeline stage: registers the execute result, runs the req/ack data access, owns LL/SC llbit.
// Latency: request in the cycle after latching; zero-wait load data is visible combinationally in that cycle.
// Backpressure: holds while a transaction is outstanding (mem_wait) or stall is high; bubble/nullify deferred to the ack.
module stage_memory
  import stage_memory_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             bubble,
  input  logic             nullify,
  input  pipeline_signal_t signal_in,
  output pipeline_signal_t signal_out,
  output logic             llbit,
  input  logic             llbit_clear,
  output logic             addr_error,
  output logic             mem_wait,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [3:0]       mem_be,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ack
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  pipeline_signal_t sig_q, sig_d, sig_in_eff;
  logic [31:0]      load_buf_q, load_buf_d;
  logic             llbit_q, llbit_d;
  logic             pend_bubble_q, pend_bubble_d;
  logic             pend_nullify_q, pend_nullify_d;

  mem_op_t          op_q;
  mem_size_t        size_q;
  logic             in_access, acked, is_load_q;
  logic [3:0]       al_be;
  logic [31:0]      al_wdata, al_load;
  logic             al_misaligned;

  assign op_q      = sig_q.control.mem_op;
  assign size_q    = eff_size(op_q, sig_q.control.mem_size);
  assign in_access = (state_q == ST_ACCESS);
  assign acked     = in_access && mem_ack;
  assign is_load_q = (op_q == MEM_LOAD) || (op_q == MEM_LL);

  memory_lane_align u_align (
    .size_i       (size_q),
    .signed_i     (sig_q.control.mem_signed),
    .addr_lo_i    (sig_q.mem_addr[1:0]),
    .rt_i         (sig_q.rt),
    .rdata_i      (mem_rdata),
    .be_o         (al_be),
    .wdata_o      (al_wdata),
    .load_data_o  (al_load),
    .misaligned_o (al_misaligned)
  );

  // Bus outputs are driven only while a transaction is in flight; otherwise idle zeros.
  always_comb begin
    mem_req    = in_access;
    mem_we     = in_access && ((op_q == MEM_STORE) || (op_q == MEM_SC));
    mem_addr   = in_access ? {sig_q.mem_addr[31:2], 2'b00} : 32'd0;
    mem_be     = in_access ? al_be : 4'd0;
    mem_wdata  = in_access ? al_wdata : 32'd0;
    mem_wait   = in_access && !mem_ack;
    addr_error = (op_q != MEM_NONE) && al_misaligned;
    llbit      = llbit_q;
    signal_out = sig_q;
    if (addr_error) signal_out.control.write_reg = 1'b0;
    if (is_load_q) signal_out.dest_reg_data = in_access ? al_load : load_buf_q;
  end

  // Next-state: reservation bit, pipeline register, FSM and deferred bubble/nullify.
  always_comb begin
    // Reservation: LL sets on its ack, completed SC clears, external clear wins.
    llbit_d = llbit_q;
    if (acked && op_q == MEM_LL) llbit_d = 1'b1;
    if (op_q == MEM_SC && !mem_wait) llbit_d = 1'b0;
    if (llbit_clear) llbit_d = 1'b0;

    sig_in_eff = signal_in;
    if (nullify || pend_nullify_q) begin
      sig_in_eff.control.write_reg  = 1'b0;
      sig_in_eff.control.write_hilo = 1'b0;
      sig_in_eff.control.mem_op     = MEM_NONE;
    end

    sig_d          = sig_q;
    state_d        = state_q;
    load_buf_d     = load_buf_q;
    pend_bubble_d  = 1'b0;
    pend_nullify_d = 1'b0;

    if (acked && is_load_q) load_buf_d = al_load;

    if (mem_wait) begin
      // Transaction outstanding: hold everything, remember bubble/nullify for the ack edge.
      pend_bubble_d  = pend_bubble_q | bubble;
      pend_nullify_d = pend_nullify_q | nullify;
    end else if (bubble || pend_bubble_q) begin
      sig_d   = '0;
      state_d = ST_IDLE;
    end else if (stall) begin
      pend_nullify_d = pend_nullify_q;
      if (acked) state_d = ST_HOLD;
    end else begin
      sig_d   = sig_in_eff;
      state_d = needs_request(sig_in_eff, llbit_d) ? ST_ACCESS : ST_IDLE;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      sig_q          <= '0;
      load_buf_q     <= 32'd0;
      llbit_q        <= 1'b0;
      pend_bubble_q  <= 1'b0;
      pend_nullify_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      sig_q          <= sig_d;
      load_buf_q     <= load_buf_d;
      llbit_q        <= llbit_d;
      pend_bubble_q  <= pend_bubble_d;
      pend_nullify_q <= pend_nullify_d;
    end
  end

endmodule

// File: tb/tb_stage_memory.sv
// Directed bench for stage_memory: hand-computed vectors for loads, stores,
// LL/SC, misalignment, hold after ack, deferred bubble and reset mid-access.
module tb_stage_memory;
    import stage_memory_pkg::*;

    logic             clk = 1'b0;
    logic             reset, stall, bubble, nullify, llbit_clear, mem_ack;
    pipeline_signal_t signal_in, signal_out;
    logic             llbit, addr_error, mem_wait, mem_req, mem_we;
    logic [31:0]      mem_addr, mem_wdata, mem_rdata;
    logic [3:0]       mem_be;
    logic [$bits(pipeline_signal_t)-1:0] out_bits;

    int vectors = 0;
    int miscompares = 0;

    assign out_bits = signal_out;

    always #5 clk = ~clk;

    stage_memory dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .bubble      (bubble),
        .nullify     (nullify),
        .signal_in   (signal_in),
        .signal_out  (signal_out),
        .llbit       (llbit),
        .llbit_clear (llbit_clear),
        .addr_error  (addr_error),
        .mem_wait    (mem_wait),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_be      (mem_be),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack)
    );

    function automatic pipeline_signal_t mk(mem_op_t op, mem_size_t sz, logic sg,
                                            logic [31:0] a, logic [31:0] rt);
        pipeline_signal_t s;
        s = '0;
        s.control.write_reg  = (op == MEM_LOAD) || (op == MEM_LL) || (op == MEM_SC);
        s.control.mem_op     = op;
        s.control.mem_size   = sz;
        s.control.mem_signed = sg;
        s.dest_reg           = 5'd3;
        s.dest_reg_data      = 32'h1111_2222;
        s.mem_addr           = a;
        s.rt                 = rt;
        return s;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; bubble = 1'b0; nullify = 1'b0;
        llbit_clear = 1'b0; mem_ack = 1'b0; mem_rdata = 32'd0; signal_in = '0;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("reset_out", out_bits, {$bits(pipeline_signal_t){1'b0}});
        chk("reset_llbit", llbit, 1'b0);
        chk("reset_req", mem_req, 1'b0);
        chk("reset_wait", mem_wait, 1'b0);
        chk("reset_be", mem_be, 4'h0);
        chk("reset_aerr", addr_error, 1'b0);

        // LW 0x100 with two wait cycles
        signal_in = mk(MEM_LOAD, SIZE_WORD, 1'b1, 32'h100, 32'h0);
        tick();
        signal_in = '0;
        #1;
        chk("lw_req", mem_req, 1'b1);
        chk("lw_addr", mem_addr, 32'h100);
        chk("lw_be", mem_be, 4'b1111);
        chk("lw_we", mem_we, 1'b0);
        chk("lw_wait1", mem_wait, 1'b1);
        tick();
        chk("lw_wait2", mem_wait, 1'b1);
        tick();
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        #1;
        chk("lw_wait_ack", mem_wait, 1'b0);
        chk("lw_data", signal_out.dest_reg_data, 32'hDEADBEEF);
        tick();
        mem_ack = 1'b0;
        #1;
        chk("lw_req_after", mem_req, 1'b0);

        // LB / LBU / LH back to back with zero-wait memory
        signal_in = mk(MEM_LOAD, SIZE_BYTE, 1'b1, 32'h103, 32'h0);
        tick();
        signal_in = mk(MEM_LOAD, SIZE_BYTE, 1'b0, 32'h103, 32'h0);
        mem_ack = 1'b1; mem_rdata = 32'h80FF_0000;
        #1;
        chk("lb_data", signal_out.dest_reg_data, 32'hFFFFFF80);
        chk("lb_be", mem_be, 4'b1000);
        tick();
        signal_in = mk(MEM_LOAD, SIZE_HALF, 1'b1, 32'h102, 32'h0);
        #1;
        chk("lbu_b2b_req", mem_req, 1'b1);
        chk("lbu_data", signal_out.dest_reg_data, 32'h00000080);
        tick();
        signal_in = '0;
        #1;
        chk("lh_data", signal_out.dest_reg_data, 32'hFFFF80FF);
        chk("lh_be", mem_be, 4'b1100);
        tick();
        mem_ack = 1'b0;

        // SB 0x201
        signal_in = mk(MEM_STORE, SIZE_BYTE, 1'b0, 32'h201, 32'h12345678);
        tick();
        signal_in = '0;
        #1;
        chk("sb_we", mem_we, 1'b1);
        chk("sb_be", mem_be, 4'b0010);
        chk("sb_wdata", mem_wdata, 32'h78787878);
        chk("sb_addr", mem_addr, 32'h200);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;

        // LL 0x40 then SC 0x40 (success), then SC again (no reservation)
        signal_in = mk(MEM_LL, SIZE_WORD, 1'b0, 32'h40, 32'h0);
        tick();
        signal_in = mk(MEM_SC, SIZE_WORD, 1'b0, 32'h40, 32'hA5A5A5A5);
        mem_ack = 1'b1; mem_rdata = 32'h0000_0007;
        #1;
        chk("ll_llbit_before", llbit, 1'b0);
        tick();
        #1;
        chk("ll_llbit_set", llbit, 1'b1);
        chk("sc_req", mem_req, 1'b1);
        chk("sc_we", mem_we, 1'b1);
        chk("sc_wdata", mem_wdata, 32'hA5A5A5A5);
        tick();
        signal_in = '0;
        mem_ack = 1'b0;
        #1;
        chk("sc_llbit_clr", llbit, 1'b0);
        chk("sc2_no_req", mem_req, 1'b0);
        tick();

        // Misaligned LW 0x102 and LH 0x101
        signal_in = mk(MEM_LOAD, SIZE_WORD, 1'b0, 32'h102, 32'h0);
        tick();
        signal_in = mk(MEM_LOAD, SIZE_HALF, 1'b1, 32'h101, 32'h0);
        #1;
        chk("lw_mis_aerr", addr_error, 1'b1);
        chk("lw_mis_req", mem_req, 1'b0);
        chk("lw_mis_wreg", signal_out.control.write_reg, 1'b0);
        tick();
        signal_in = '0;
        #1;
        chk("lh_mis_aerr", addr_error, 1'b1);
        chk("lh_mis_req", mem_req, 1'b0);
        chk("lh_mis_wreg", signal_out.control.write_reg, 1'b0);
        tick();
        chk("mis_clear", addr_error, 1'b0);

        // Stall during ack: hold from load_buf
        signal_in = mk(MEM_LOAD, SIZE_WORD, 1'b0, 32'h300, 32'h0);
        tick();
        signal_in = '0;
        stall = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        #1;
        chk("hold_ack_data", signal_out.dest_reg_data, 32'hCAFEF00D);
        tick();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        #1;
        chk("hold_req1", mem_req, 1'b0);
        chk("hold_data1", signal_out.dest_reg_data, 32'hCAFEF00D);
        tick();
        chk("hold_req2", mem_req, 1'b0);
        chk("hold_data2", signal_out.dest_reg_data, 32'hCAFEF00D);
        stall = 1'b0;
        tick();
        chk("hold_exit_req", mem_req, 1'b0);

        // Bubble during ACCESS is deferred to the ack edge
        signal_in = mk(MEM_LOAD, SIZE_WORD, 1'b0, 32'h500, 32'h0);
        tick();
        signal_in = mk(MEM_STORE, SIZE_WORD, 1'b0, 32'h600, 32'h5);
        bubble = 1'b1;
        tick();
        bubble = 1'b0;
        #1;
        chk("bub_req_kept", mem_req, 1'b1);
        chk("bub_addr_kept", mem_addr, 32'h500);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        #1;
        chk("bub_applied", out_bits, {$bits(pipeline_signal_t){1'b0}});
        chk("bub_no_req", mem_req, 1'b0);
        signal_in = '0;

        // llbit_clear beats an LL set in the same cycle
        signal_in = mk(MEM_LL, SIZE_WORD, 1'b0, 32'h80, 32'h0);
        tick();
        signal_in = mk(MEM_LL, SIZE_WORD, 1'b0, 32'h84, 32'h0);
        mem_ack = 1'b1; llbit_clear = 1'b1;
        tick();
        llbit_clear = 1'b0;
        signal_in = mk(MEM_LOAD, SIZE_WORD, 1'b0, 32'h700, 32'h0);
        #1;
        chk("llclr_prio", llbit, 1'b0);
        tick();
        signal_in = '0;
        mem_ack = 1'b0;
        #1;
        chk("ll2_set", llbit, 1'b1);
        chk("rst_pre_req", mem_req, 1'b1);

        // Reset mid-ACCESS, then a late ack
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("rst_mid_req", mem_req, 1'b0);
        chk("rst_mid_out", out_bits, {$bits(pipeline_signal_t){1'b0}});
        chk("rst_mid_llbit", llbit, 1'b0);
        chk("rst_mid_wait", mem_wait, 1'b0);
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
        tick();
        mem_ack = 1'b0;
        #1;
        chk("late_ack_req", mem_req, 1'b0);
        chk("late_ack_out", out_bits, {$bits(pipeline_signal_t){1'b0}});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stage_memory.md
# stage_memory

Pipeline stage directly downstream of `stage_execute`. It registers the execute result, performs the data-memory access through a req/ack bus using `mem_addr`, `rt` and the control word, and aligns and sign-extends load data into `dest_reg_data`. It owns the LL/SC `llbit` register that `stage_execute` consumes. It raises `mem_wait` toward the hazard unit while a bus transaction is outstanding.

## Interface
Parameters:
- none

Ports (clock and reset first):
- Reset is synchronous and active-high. The stage has one clock.
- `clk` input, 1: stage clock; all state updates on its rising edge.
- `reset` input, 1: synchronous, active-high.
- `stall` input, 1: hold the pipeline register.
- `bubble` input, 1: load an all-zero (nop) signal into the register.
- `nullify` input, 1: latch the incoming instruction with `write_reg`, `write_hilo` and memory op cleared.
- `signal_in` input, `pipeline_signal_t`: execute output.
- `signal_out` output, `pipeline_signal_t`: registered signal. For loads, `dest_reg_data` is replaced by aligned load data.
- `llbit` output, 1: LL reservation bit; feeds `stage_execute`.
- `llbit_clear` input, 1: clears `llbit` (driven by ERET / exception).
- `addr_error` output, 1: misaligned access on the registered instruction.
- `mem_wait` output, 1: bus transaction outstanding; the hazard unit stalls upstream.
- `mem_req` output, 1: bus request.
- `mem_we` output, 1: write request.
- `mem_addr` output, 32: word address; bits [1:0] are always 0.
- `mem_be` output, 4: byte enables; bit i corresponds to byte lane i (little-endian).
- `mem_wdata` output, 32: lane-aligned store data.
- `mem_rdata` input, 32: read data, valid when `mem_ack` is high.
- `mem_ack` input, 1: transaction complete (one-cycle pulse).

## Operation
- Register update priority: `reset` > `bubble` > `stall` > load `signal_in`. A stall forced by the stage's own `mem_wait` also holds the register.
- Memory op comes from `control.mem_op`: NONE, LOAD, STORE, LL, SC. Size comes from `control.mem_size`: BYTE, HALF, WORD. Sign comes from `control.mem_signed`.
- Misalignment: HALF with `addr[0]`=1, or WORD with `addr[1:0]`≠0.
  - Sets `addr_error` combinationally.
  - No bus request is made.
  - `write_reg` out is forced to 0.
- Store lanes:
  - BYTE: `be` = 1<<a[1:0], data = {4{rt[7:0]}}.
  - HALF: `be` = a[1] ? 1100 : 0011, data = {2{rt[15:0]}}.
  - WORD: `be` = 1111, data = rt.
- Load extract: select the byte or half from `rdata` by `a[1:0]`, then zero- or sign-extend to 32 bits.
- SC:
  - If `llbit` = 0, no bus request is made and the instruction completes immediately.
  - If `llbit` = 1, a WORD store is performed.
  - In both cases `llbit` is cleared at completion.
  - The rt write of the SC success flag is already decided in execute via `write_cond`.
- LL: a WORD load that sets `llbit` at completion (the ack edge).
- `llbit_clear` has priority over an LL set in the same cycle.
- State machine:
  - IDLE:
    - An accepted register load with an aligned, request-needing op moves to ACCESS.
    - Otherwise stay in IDLE.
  - ACCESS:
    - `mem_req`=1, with `mem_we`/`be`/`addr`/`wdata` from the registered instruction.
    - On `mem_ack`: capture extracted data in `load_buf`.
    - Next state is HOLD if `stall` is high, else IDLE. If `stall` is low, a new instruction may be latched on the same edge; if it needs a request, go directly to ACCESS.
  - HOLD:
    - `mem_req`=0; outputs come from `load_buf`; no re-request.
    - Leave when `stall` falls, via the same latch rule as IDLE.
- `bubble` and `nullify` arriving during ACCESS are deferred: they are applied at the edge where `mem_ack` occurs. The transaction is never abandoned.

## Timing
- Reset values:
  - `signal_out`=0, `llbit`=0, state IDLE, `load_buf`=0.
  - `mem_req`=0, `mem_we`=0, `mem_be`=0, `mem_addr`=0, `mem_wdata`=0.
  - `mem_wait`=0, `addr_error`=0.
- Memory instruction latched at edge N gives `mem_req`=1 in cycle N+1.
- `mem_wait` = (state==ACCESS) && !`mem_ack`.
- Zero-wait memory (ack in N+1): load data appears on `dest_reg_data` combinationally in N+1, and the stage accepts the next instruction at edge N+2.
- Ack after k wait cycles: `mem_wait` is high for k cycles.
- `mem_req` stays high and the bus outputs stay stable until the ack cycle inclusive.
- `reset` mid-ACCESS: go to IDLE next edge, `mem_req` drops, and a late ack is ignored.
- Back-to-back memory ops issue with no idle cycle between them.

## Structure
- Shared package additions:
  - `selector::mem_op`, `selector::mem_size` enums.
  - `control_t` fields `mem_op`, `mem_size`, `mem_signed`.
- FSM state enum stays local to the module.
- Sub-module: `memory_lane_align`, combinational.
  - Inputs: size, signed, `addr[1:0]`, rt, rdata.
  - Outputs: be, wdata, load_data, misaligned.

## Test plan
- LW at `addr` 0x100, ack after 2 waits, `rdata` 0xDEADBEEF: `mem_wait` high for 2 cycles, then `dest_reg_data`=0xDEADBEEF; `mem_addr`=0x100, `be`=1111.
- LB at 0x103 with `rdata` 0x80FF_0000: result 0xFFFFFF80. LBU at the same address: result 0x00000080. LH at 0x102: result 0xFFFF80FF.
- SB at 0x201, rt=0x12345678: `mem_we`=1, `be`=0010, `wdata`=0x78787878, `addr`=0x200.
- LL at 0x40, then SC at 0x40: `llbit` is 1 after the LL ack, the SC store is issued, and `llbit` is 0 after it. Repeating SC with `llbit`=0: no `mem_req`.
- LW at 0x102: `addr_error`=1, `mem_req` never asserted, `write_reg`=0. LH at 0x101 gives the same response.
- `stall` high during ack, held 3 cycles: state HOLD, `mem_req`=0, `dest_reg_data` stable from `load_buf`. `reset` during ACCESS: `mem_req`=0 next cycle and all outputs at reset values.
